// File: rtl/gray_conv_pipe_if.sv
// Streaming valid/ready bundle for gray_conv_pipe: input word side and converted-word side.
// A word moves across a side on a rising clk edge where valid and ready are both 1; a source holds its word until then.
interface gray_conv_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;
    logic             out_seq_err;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_seq_err
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_seq_err
    );
endinterface

// File: rtl/gray_conv_pipe.sv
// Elastic STAGES-deep Gray<->binary converter; Gray-to-binary prefix XOR is spread MSB-first over the stages.
// Define GRAY_CONV_SEQCHK_EN to flag Gray words whose Hamming distance from the previous Gray word is not 1.
module gray_conv_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    gray_conv_pipe_if.slave bus
);
    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_param
        $error("gray_conv_pipe: WIDTH must be 2..64 and STAGES 1..WIDTH");
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] mode_q,  mode_d;
    logic [STAGES-1:0] err_q,   err_d;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  res_q  [STAGES];
    logic [WIDTH-1:0]  res_d  [STAGES];
    logic [WIDTH-1:0]  code_q [STAGES];
    logic [WIDTH-1:0]  code_d [STAGES];
    logic [STAGES:0]   slot_rdy;

    // Source of each slot: index 0 is the input port, index k+1 is slot k.
    logic [STAGES:0]   src_valid;
    logic [STAGES:0]   src_mode;
    logic [STAGES:0]   src_err;
    logic [WIDTH-1:0]  src_res  [STAGES+1];
    logic [WIDTH-1:0]  src_code [STAGES+1];
    logic              in_err;

    // Resolves this stage's slice of binary bits; bits above the slice are already final in part.
    function automatic logic [WIDTH-1:0] g2b_chunk(input logic [WIDTH-1:0] part,
                                                   input logic [WIDTH-1:0] gray,
                                                   input int               stage);
        int               hi;
        int               lo;
        logic [WIDTH-1:0] r;
        logic             c;
        hi = WIDTH - 1 - stage * CHUNK;
        lo = (stage == STAGES - 1) ? 0 : WIDTH - (stage + 1) * CHUNK;
        if (lo < 0) lo = 0;
        r = part;
        c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= hi && i >= lo) r[i] = c ^ gray[i];
            c = r[i];
        end
        return r;
    endfunction

`ifdef GRAY_CONV_SEQCHK_EN
    logic [WIDTH-1:0] last_gray_q;
    logic             have_last_q;
    logic             gray_acc;

    assign gray_acc = bus.in_valid && slot_rdy[0] && !bus.in_mode;
    assign in_err   = have_last_q && ($countones(bus.in_data ^ last_gray_q) != 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gray_q <= '0;
            have_last_q <= 1'b0;
        end else if (gray_acc) begin
            last_gray_q <= bus.in_data;
            have_last_q <= 1'b1;
        end
    end
`else
    assign in_err = 1'b0;
`endif

    assign src_valid[0] = bus.in_valid;
    assign src_mode[0]  = bus.in_mode;
    assign src_err[0]   = in_err & ~bus.in_mode;
    assign src_res[0]   = '0;
    assign src_code[0]  = bus.in_data;
    assign slot_rdy[STAGES] = bus.out_ready;

    // A slot can take a word if it is empty or every slot after it up to the output can move.
    for (genvar k = 0; k < STAGES; k++) begin : g_chain
        assign src_valid[k+1] = valid_q[k];
        assign src_mode[k+1]  = mode_q[k];
        assign src_err[k+1]   = err_q[k];
        assign src_res[k+1]   = res_q[k];
        assign src_code[k+1]  = code_q[k];
        assign slot_rdy[k]    = bus.out_ready | ~(&valid_q[STAGES-1:k]);
    end

    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        err_d   = err_q;
        load    = '0;
        res_d   = res_q;
        code_d  = code_q;
        for (int k = 0; k < STAGES; k++) begin
            if (slot_rdy[k]) valid_d[k] = src_valid[k];
            load[k] = slot_rdy[k] & src_valid[k];
            if (load[k]) begin
                mode_d[k] = src_mode[k];
                err_d[k]  = src_err[k];
                code_d[k] = src_code[k];
                if (src_mode[k]) begin
                    res_d[k] = (k == 0) ? (src_code[k] ^ (src_code[k] >> 1)) : src_res[k];
                end else begin
                    res_d[k] = g2b_chunk(src_res[k], src_code[k], k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            mode_q  <= '0;
            err_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k]  <= '0;
                code_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            res_q   <= res_d;
            code_q  <= code_d;
        end
    end

    assign bus.in_ready    = slot_rdy[0];
    assign bus.out_valid   = valid_q[STAGES-1];
    assign bus.out_mode    = mode_q[STAGES-1];
    assign bus.out_data    = res_q[STAGES-1];
    assign bus.out_seq_err = err_q[STAGES-1];
endmodule
